// File: rtl/serial_frame_master_if.sv
// Host-side and serial-link signals of serial_frame_master.
// master = the frame engine; slave = the host/bench side.
interface serial_frame_master_if #(
  parameter int DATA_WIDTH = 171,
  parameter int NUM_CS     = 1
);
  localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  start;
  logic [CSW-1:0]        cs_sel;
  logic                  cpol;
  logic                  cpha;
  logic                  lsb_first;
  logic [DATA_WIDTH-1:0] parallel_in;
  logic [DATA_WIDTH-1:0] parallel_out;
  logic                  busy;
  logic                  done;
  logic                  ser_clk;
  logic                  ser_data_out;
  logic                  ser_data_in;
  logic [NUM_CS-1:0]     ser_cs;

  modport master (
    input  start, cs_sel, cpol, cpha, lsb_first, parallel_in, ser_data_in,
    output parallel_out, busy, done, ser_clk, ser_data_out, ser_cs
  );

  modport slave (
    output start, cs_sel, cpol, cpha, lsb_first, parallel_in, ser_data_in,
    input  parallel_out, busy, done, ser_clk, ser_data_out, ser_cs
  );
endinterface

// File: rtl/serial_frame_master.sv
// Start/done serial frame master: programmable divider, CPOL/CPHA modes, MSB/LSB order, multi-CS.
// Define SERIAL_FRAME_MASTER_LOOPBACK_EN to sample the internal transmit register instead of ser_data_in.
module serial_frame_master #(
  parameter int DATA_WIDTH = 171,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_frame_master_if.master   bus
);
  localparam int CSW  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ECW  = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [ECW-1:0]  EDGE_LAST = ECW'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_nxt;

  logic [DIVW-1:0]       div_cnt;
  logic [ECW-1:0]        edge_cnt;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, pout_q;
  logic                  cpol_q, cpha_q, lsb_q;
  logic                  ser_clk_q, sdo_q, busy_q, done_q;
  logic [NUM_CS-1:0]     cs_q, cs_dec;

  logic                  tick, accept, sample_bit, head, do_sample, do_drive;
  logic [ECW-1:0]        edge_nxt;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift;

  assign bus.parallel_out = pout_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.ser_clk      = ser_clk_q;
  assign bus.ser_data_out = sdo_q;
  assign bus.ser_cs       = cs_q;

`ifdef SERIAL_FRAME_MASTER_LOOPBACK_EN
  assign sample_bit = sdo_q;
`else
  assign sample_bit = bus.ser_data_in;
`endif

  // busy is still high in the done cycle, so a held start waits one IDLE cycle
  assign accept   = (state == IDLE) && bus.start && !busy_q;
  assign tick     = (div_cnt == DIV_LAST);
  assign edge_nxt = edge_cnt + 1'b1;

  // odd edges are leading; sample on leading for cpha=0, trailing for cpha=1
  assign do_sample = (edge_nxt[0] != cpha_q);
  assign do_drive  = !do_sample && (edge_nxt != EDGE_LAST);

  assign head     = lsb_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
  assign tx_shift = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
  assign rx_shift = lsb_q ? {sample_bit, rx_sr[DATA_WIDTH-1:1]}
                          : {rx_sr[DATA_WIDTH-2:0], sample_bit};

  // out-of-range cs_sel leaves every line deasserted
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++)
      cs_dec[i] = (bus.cs_sel != CSW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && edge_nxt == EDGE_LAST) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      edge_cnt  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      pout_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      ser_clk_q <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= '1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          edge_cnt  <= '0;
          ser_clk_q <= bus.cpol;
          sdo_q     <= 1'b0;
          busy_q    <= 1'b0;
          if (accept) begin
            cpol_q <= bus.cpol;
            cpha_q <= bus.cpha;
            lsb_q  <= bus.lsb_first;
            cs_q   <= cs_dec;
            busy_q <= 1'b1;
            rx_sr  <= '0;
            // cpha=0 presents the first bit before the first leading edge
            if (!bus.cpha) begin
              sdo_q <= bus.lsb_first ? bus.parallel_in[0] : bus.parallel_in[DATA_WIDTH-1];
              tx_sr <= bus.lsb_first ? (bus.parallel_in >> 1) : (bus.parallel_in << 1);
            end else begin
              tx_sr <= bus.parallel_in;
            end
          end
        end
        SETUP, SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            edge_cnt  <= edge_nxt;
            ser_clk_q <= ~ser_clk_q;
            if (do_sample) rx_sr <= rx_shift;
            if (do_drive) begin
              sdo_q <= head;
              tx_sr <= tx_shift;
            end
          end
        end
        HOLD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            cs_q      <= '1;
            done_q    <= 1'b1;
            pout_q    <= rx_sr;
            sdo_q     <= 1'b0;
            ser_clk_q <= cpol_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_frame_master.sv
// Bench for serial_frame_master: an SPI-style slave model on DUT a, loopback-wired DUT b.
module tb_serial_frame_master;
  localparam int W     = 8;
  localparam int LAT_A = 1 + (2 * W + 1) * 2;
  localparam int LAT_B = 1 + (2 * W + 1) * 1;

  logic clk, rst;
  int   cyc = 0;
  int   errs = 0, checks = 0;

  serial_frame_master_if #(.DATA_WIDTH(W), .NUM_CS(4)) bus_a ();
  serial_frame_master_if #(.DATA_WIDTH(W), .NUM_CS(3)) bus_b ();

  serial_frame_master #(.DATA_WIDTH(W), .CLK_DIV(2), .NUM_CS(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  serial_frame_master #(.DATA_WIDTH(W), .CLK_DIV(1), .NUM_CS(3)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model state for DUT a
  logic       sdi;
  logic       m_cpha, m_lsb;
  logic [7:0] s_word;
  logic       tx_seen[$];
  logic [3:0] cs_first, cs_last;
  int         edge_n = 0, done_cnt = 0;
  logic       prev_clk = 1'b0;

  assign bus_a.ser_data_in = sdi;
  assign bus_b.ser_data_in = bus_b.ser_data_out;

  function automatic logic bitof(input logic [7:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[7 - i];
  endfunction

  function automatic logic [7:0] seen_word(input logic lsb);
    logic [7:0] w = '0;
    for (int i = 0; i < tx_seen.size() && i < 8; i++)
      if (lsb) w[i] = tx_seen[i]; else w[7 - i] = tx_seen[i];
    return w;
  endfunction

  // slave: drives the next bit on its launch edge, records master data on the sample edge
  initial forever begin
    @(negedge clk);
    if (!bus_a.busy) edge_n = 0;
    else if (bus_a.ser_clk !== prev_clk) begin
      int k;
      logic samp;
      edge_n++;
      samp = m_cpha ? (edge_n % 2 == 0) : (edge_n % 2 == 1);
      if (samp) tx_seen.push_back(bus_a.ser_data_out);
      else begin
        k = m_cpha ? (edge_n - 1) / 2 : edge_n / 2;
        if (k < W) sdi = bitof(s_word, k, m_lsb);
      end
      if (edge_n == 1) cs_first = bus_a.ser_cs;
      if (edge_n == 2 * W) cs_last = bus_a.ser_cs;
    end
    prev_clk = bus_a.ser_clk;
    if (bus_a.done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_rx(input logic [7:0] pi, input logic [7:0] sw);
`ifdef SERIAL_FRAME_MASTER_LOOPBACK_EN
    return pi;
`else
    return sw;
`endif
  endfunction

  task automatic run_frame(input logic [7:0] pi, input logic [7:0] sw, input logic [1:0] cs,
                           input logic pol, input logic pha, input logic lsb, input int poke_at,
                           output int lat, output logic [7:0] rx);
    int t0;
    tick();
    bus_a.start = 1'b0; bus_a.parallel_in = pi; bus_a.cs_sel = cs;
    bus_a.cpol = pol; bus_a.cpha = pha; bus_a.lsb_first = lsb;
    m_cpha = pha; m_lsb = lsb; s_word = sw; sdi = bitof(sw, 0, lsb);
    tx_seen.delete();
    tick();
    bus_a.start = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (cyc - t0 == 1) bus_a.start = 1'b0;
      if (poke_at > 0 && cyc - t0 == poke_at) begin
        bus_a.parallel_in = ~pi; bus_a.cs_sel = cs ^ 2'd1;
        bus_a.cpol = ~pol; bus_a.cpha = ~pha; bus_a.lsb_first = ~lsb;
        bus_a.start = 1'b1;
      end
      if (poke_at > 0 && cyc - t0 == poke_at + 1) bus_a.start = 1'b0;
      if (bus_a.done) begin lat = cyc - t0; break; end
    end
    rx = bus_a.parallel_out;
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus_a.parallel_out !== 8'h00) begin errs++; $display("FAIL reset_pout got=%h want=00", bus_a.parallel_out); end
    checks++; if (bus_a.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", bus_a.busy); end
    checks++; if (bus_a.done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b want=0", bus_a.done); end
    checks++; if (bus_a.ser_clk !== 1'b0) begin errs++; $display("FAIL reset_sclk got=%b want=0", bus_a.ser_clk); end
    checks++; if (bus_a.ser_data_out !== 1'b0) begin errs++; $display("FAIL reset_sdo got=%b want=0", bus_a.ser_data_out); end
    checks++; if (bus_a.ser_cs !== 4'hF) begin errs++; $display("FAIL reset_cs got=%b want=1111", bus_a.ser_cs); end
  endtask

  task automatic test_mode0();
    int lat; logic [7:0] rx;
    run_frame(8'hA5, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 0, lat, rx);
    checks++; if (lat !== LAT_A) begin errs++; $display("FAIL mode0_latency got=%0d want=%0d", lat, LAT_A); end
    checks++; if (rx !== 8'hA5) begin errs++; $display("FAIL mode0_rx got=%h want=a5", rx); end
    checks++; if (tx_seen.size() != W || seen_word(1'b0) !== 8'hA5) begin
      errs++; $display("FAIL mode0_tx got=%h (n=%0d) want=a5", seen_word(1'b0), tx_seen.size()); end
    checks++; if (cs_first !== 4'b1110) begin errs++; $display("FAIL mode0_cs got=%b want=1110", cs_first); end
  endtask

  task automatic test_mode3_lsb();
    int lat; logic [7:0] rx;
    tick(); bus_a.cpol = 1'b1;
    tick(); tick();
    checks++; if (bus_a.ser_clk !== 1'b1) begin errs++; $display("FAIL mode3_idle_sclk got=%b want=1", bus_a.ser_clk); end
    run_frame(8'h01, 8'h3C, 2'd1, 1'b1, 1'b1, 1'b1, 0, lat, rx);
    checks++; if (tx_seen.size() == 0 || tx_seen[0] !== 1'b1) begin errs++; $display("FAIL mode3_first_bit got=%0d bits want first=1", tx_seen.size()); end
    checks++; if (rx !== exp_rx(8'h01, 8'h3C)) begin errs++; $display("FAIL mode3_rx got=%h want=%h", rx, exp_rx(8'h01, 8'h3C)); end
    checks++; if (lat !== LAT_A) begin errs++; $display("FAIL mode3_latency got=%0d want=%0d", lat, LAT_A); end
    checks++; if (bus_a.ser_clk !== 1'b1) begin errs++; $display("FAIL mode3_end_sclk got=%b want=1", bus_a.ser_clk); end
  endtask

  task automatic test_reset_mid();
    int dc; logic seen5 = 1'b0;
    tick();
    bus_a.cpol = 1'b0; bus_a.cpha = 1'b0; bus_a.lsb_first = 1'b0; bus_a.cs_sel = 2'd3;
    bus_a.parallel_in = 8'($urandom); m_cpha = 1'b0; m_lsb = 1'b0; s_word = 8'hFF; sdi = 1'b1;
    tick(); bus_a.start = 1'b1;
    tick(); bus_a.start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (edge_n == 5) begin seen5 = 1'b1; break; end
      tick();
    end
    checks++; if (!seen5) begin errs++; $display("FAIL rstmid_reach_edge5 got=%0d want=5", edge_n); end
    dc = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus_a.ser_cs !== 4'hF) begin errs++; $display("FAIL rstmid_cs got=%b want=1111", bus_a.ser_cs); end
    checks++; if (bus_a.busy !== 1'b0) begin errs++; $display("FAIL rstmid_busy got=%b want=0", bus_a.busy); end
    checks++; if (bus_a.parallel_out !== 8'h00) begin errs++; $display("FAIL rstmid_pout got=%h want=00", bus_a.parallel_out); end
    checks++; if (bus_a.ser_data_out !== 1'b0) begin errs++; $display("FAIL rstmid_sdo got=%b want=0", bus_a.ser_data_out); end
    repeat (60) tick();
    checks++; if (done_cnt != dc) begin errs++; $display("FAIL rstmid_no_done got=%0d want=%0d", done_cnt, dc); end
  endtask

  task automatic test_cs_protect();
    int lat, dc; logic [7:0] rx, pi, sw;
    pi = 8'($urandom); sw = 8'($urandom) | 8'h81;
    dc = done_cnt;
    run_frame(pi, sw, 2'd2, 1'b0, 1'b1, 1'b0, 10, lat, rx);
    repeat (50) tick();
    checks++; if (cs_first !== 4'b1011 || cs_last !== 4'b1011) begin
      errs++; $display("FAIL csprot_cs got=%b/%b want=1011", cs_first, cs_last); end
    checks++; if (done_cnt - dc != 1) begin errs++; $display("FAIL csprot_done_count got=%0d want=1", done_cnt - dc); end
    checks++; if (seen_word(1'b0) !== pi) begin errs++; $display("FAIL csprot_tx got=%h want=%h", seen_word(1'b0), pi); end
    checks++; if (rx !== exp_rx(pi, sw)) begin errs++; $display("FAIL csprot_rx got=%h want=%h", rx, exp_rx(pi, sw)); end
    checks++; if (lat !== LAT_A) begin errs++; $display("FAIL csprot_latency got=%0d want=%0d", lat, LAT_A); end
  endtask

  task automatic test_random();
    int lat; logic [7:0] rx, pi, sw; logic [1:0] cs; logic pol, pha, lsb; logic [3:0] ecs;
    for (int it = 0; it < 6; it++) begin
      pi = 8'($urandom); sw = 8'($urandom); cs = 2'($urandom_range(0, 3));
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
      ecs = ~(4'b0001 << cs);
      run_frame(pi, sw, cs, pol, pha, lsb, 0, lat, rx);
      checks++; if (lat !== LAT_A) begin errs++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, lat, LAT_A); end
      checks++; if (rx !== exp_rx(pi, sw)) begin errs++; $display("FAIL rand%0d_rx mode=%b%b%b got=%h want=%h", it, pol, pha, lsb, rx, exp_rx(pi, sw)); end
      checks++; if (tx_seen.size() != W || seen_word(lsb) !== pi) begin
        errs++; $display("FAIL rand%0d_tx mode=%b%b%b got=%h want=%h", it, pol, pha, lsb, seen_word(lsb), pi); end
      checks++; if (cs_first !== ecs || cs_last !== ecs) begin
        errs++; $display("FAIL rand%0d_cs got=%b/%b want=%b", it, cs_first, cs_last, ecs); end
      checks++; if (bus_a.ser_clk !== pol) begin errs++; $display("FAIL rand%0d_idle_sclk got=%b want=%b", it, bus_a.ser_clk, pol); end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, last_td = -1, idle_cnt = 0, tog = 0, tfirst = -1, tlast = -1, cs_bad = 0;
    logic prev; logic [7:0] p; logic [7:0] q[$];
    tick();
    p = 8'($urandom);
    bus_b.parallel_in = p; bus_b.cpol = 1'b0; bus_b.cpha = 1'($urandom);
    bus_b.lsb_first = 1'($urandom); bus_b.cs_sel = 2'd3;
    q.push_back(p);
    bus_b.start = 1'b1;
    prev = bus_b.ser_clk;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (bus_b.busy && bus_b.ser_clk !== prev) begin
        tog++; if (tfirst < 0) tfirst = cyc; tlast = cyc;
      end
      prev = bus_b.ser_clk;
      if (bus_b.busy && bus_b.ser_cs !== 3'b111) cs_bad++;
      if (!bus_b.busy) idle_cnt++;
      if (bus_b.done) begin
        dones++;
        p = q.pop_front();
        checks++; if (bus_b.parallel_out !== p) begin errs++; $display("FAIL b2b%0d_rx got=%h want=%h", dones, bus_b.parallel_out, p); end
        checks++; if (tog != 2 * W || tlast - tfirst != 2 * W - 1) begin
          errs++; $display("FAIL b2b%0d_sclk toggles=%0d span=%0d want=%0d/%0d", dones, tog, tlast - tfirst, 2 * W, 2 * W - 1); end
        if (dones > 1) begin
          checks++; if (cyc - last_td != LAT_B + 1) begin errs++; $display("FAIL b2b%0d_spacing got=%0d want=%0d", dones, cyc - last_td, LAT_B + 1); end
          checks++; if (idle_cnt != 1) begin errs++; $display("FAIL b2b%0d_idle_gap got=%0d want=1", dones, idle_cnt); end
        end
        last_td = cyc; idle_cnt = 0; tog = 0; tfirst = -1;
        if (dones == 3) begin bus_b.start = 1'b0; break; end
        p = 8'($urandom);
        bus_b.parallel_in = p; bus_b.cpha = 1'($urandom); bus_b.lsb_first = 1'($urandom);
        q.push_back(p);
      end
    end
    bus_b.start = 1'b0;
    checks++; if (dones != 3) begin errs++; $display("FAIL b2b_frames got=%0d want=3", dones); end
    checks++; if (cs_bad != 0) begin errs++; $display("FAIL b2b_cs_out_of_range asserted_cycles=%0d want=0", cs_bad); end
  endtask

  initial begin
    rst = 1'b1; sdi = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0; s_word = '0;
    cs_first = '1; cs_last = '1;
    bus_a.start = 1'b0; bus_a.cs_sel = '0; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0;
    bus_a.lsb_first = 1'b0; bus_a.parallel_in = '0;
    bus_b.start = 1'b0; bus_b.cs_sel = '0; bus_b.cpol = 1'b0; bus_b.cpha = 1'b0;
    bus_b.lsb_first = 1'b0; bus_b.parallel_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_reset_mid();
    test_cs_protect();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
